// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer block.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    ISSUE    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the PC register, instruction memory and decode.
// FetchCount/StallCount exist only when FETCH_PERF_EN is defined.
interface fetch_sequencer_if;
  logic [31:0] PcOut;
  logic [31:0] PcIn;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  modport master (
    input  PcOut, ImemAck, ImemData, BranchTaken, BranchTarget, Stall,
`ifdef FETCH_PERF_EN
    output FetchCount, StallCount,
`endif
    output PcIn, ImemReq, ImemAddr, InstrValid, Instr, InstrPc
  );

  modport slave (
    output PcOut, ImemAck, ImemData, BranchTaken, BranchTarget, Stall,
`ifdef FETCH_PERF_EN
    input  FetchCount, StallCount,
`endif
    input  PcIn, ImemReq, ImemAddr, InstrValid, Instr, InstrPc
  );
endinterface

// File: rtl/fetch_perf_counter.sv
// Free-running 32-bit fetch/stall event counters; instantiated only under FETCH_PERF_EN.
module fetch_perf_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count
);
  logic [1:0] w_inc;
  assign w_inc = {i_stall_inc, i_fetch_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] r_count;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          r_count <= '0;
        else if (w_inc[gi])
          r_count <= r_count + 32'd1;
      end
    end
  endgenerate

  assign o_fetch_count = g_cnt[0].r_count;
  assign o_stall_count = g_cnt[1].r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC generation and one-outstanding instruction fetch with decode back-pressure.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic              clock,
  input logic              reset,
  fetch_sequencer_if.master bus
);
  fetch_state_t r_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;

  logic w_fetch;
  logic w_issue;
  logic w_take_ack;

  assign w_fetch    = (r_state == FETCH);
  assign w_issue    = (r_state == ISSUE);
  assign w_take_ack = w_fetch && bus.ImemAck && !bus.BranchTaken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (bus.BranchTaken) begin
      r_state <= REDIRECT;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.ImemAck) begin
            r_instr    <= bus.ImemData;
            r_instr_pc <= bus.PcOut;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.Stall)
            r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Reset forces the PC register to load RESET_PC and suppresses the request.
  always_comb begin
    if (reset)
      bus.PcIn = RESET_PC;
    else if (bus.BranchTaken)
      bus.PcIn = align_word(bus.BranchTarget);
    else if (w_take_ack)
      bus.PcIn = bus.PcOut + 32'(INSTR_BYTES);
    else
      bus.PcIn = bus.PcOut;
  end

  assign bus.ImemReq    = w_fetch && !reset;
  assign bus.ImemAddr   = bus.PcOut;
  assign bus.InstrValid = w_issue;
  assign bus.Instr      = r_instr;
  assign bus.InstrPc    = r_instr_pc;

`ifdef FETCH_PERF_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = w_issue && !bus.Stall && !bus.BranchTaken;
  assign w_stall_inc = !bus.BranchTaken &&
                       ((w_issue && bus.Stall) || (w_fetch && !bus.ImemAck));

  fetch_perf_counter u_perf (
    .clock         (clock),
    .reset         (reset),
    .i_fetch_inc   (w_fetch_inc),
    .i_stall_inc   (w_stall_inc),
    .o_fetch_count (bus.FetchCount),
    .o_stall_count (bus.StallCount)
  );
`endif
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Next-PC and instruction-fetch sequencer for the single-issue core. It consumes the current program-counter value, drives the next value back into the program-counter register and runs a one-outstanding request/acknowledge fetch to instruction memory. Fetched instructions are presented to decode with a stall back-pressure, and taken branches are redirected with priority. It sits between the program-counter register, instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000, address loaded into the PC while reset is asserted (word aligned)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- PcOut  in  32  current PC from the program-counter register
- PcIn  out  32  next PC; the register loads it on every rising edge
- ImemReq  out  1  fetch request; high until acknowledged or cancelled
- ImemAddr  out  32  fetch address, equal to PcOut
- ImemAck  in  1  single-cycle acknowledge; ImemData is valid in the same cycle
- ImemData  in  32  fetched instruction word
- BranchTaken  in  1  redirect request from execute
- BranchTarget  in  32  redirect address; bits [1:0] ignored
- Stall  in  1  decode cannot accept Instr this cycle
- InstrValid  out  1  Instr/InstrPc valid for decode
- Instr  out  32  buffered instruction
- InstrPc  out  32  address Instr was fetched from
- FetchCount  out  32  instructions accepted by decode (FETCH_PERF_EN only)
- StallCount  out  32  fetch stall cycles (FETCH_PERF_EN only)

## Operation
- States:
  - FETCH: request outstanding.
  - ISSUE: instruction held for decode.
  - REDIRECT: one idle cycle after a branch.
- Reset:
  - State goes to FETCH.
  - InstrValid, Instr and InstrPc go to 0.
  - Counters go to 0.
  - While reset is high, PcIn = RESET_PC combinationally and ImemReq = 0.
- FETCH:
  - ImemReq = 1, ImemAddr = PcOut.
  - Without ImemAck: PcIn = PcOut; stay in FETCH.
  - With ImemAck: Instr <= ImemData, InstrPc <= PcOut, PcIn = PcOut + 4; go to ISSUE.
- ISSUE:
  - InstrValid = 1, ImemReq = 0, PcIn = PcOut.
  - Stall = 0: decode accepts the instruction this cycle; go to FETCH.
  - Stall = 1: hold Instr and InstrPc unchanged.
- REDIRECT: ImemReq = 0, InstrValid = 0, PcIn = PcOut; go to FETCH.
- BranchTaken in any state overrides all of the above:
  - PcIn = {BranchTarget[31:2], 2'b00}; next state is REDIRECT.
  - An ImemAck in the same cycle is discarded and Instr is not updated.
  - InstrValid in that cycle does not count as accepted.
- Cancellation:
  - Deasserting ImemReq before ImemAck cancels the request.
  - Memory never asserts ImemAck while ImemReq = 0.
- Arithmetic: PC + 4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 0.

## Timing
- Sequencing:
  - Ack at cycle N: InstrValid = 1 at N+1.
  - Accepted at N+1: next ImemReq at N+2.
  - Peak throughput is one instruction every 2 cycles.
- ImemAddr changes only on acceptance or redirect, never while ImemReq is high and unacknowledged.
- Branch at cycle N:
  - PcOut = target at N+1 (REDIRECT, no request).
  - ImemReq with ImemAddr = target at N+2.
- PcIn, ImemReq, ImemAddr and InstrValid are combinational from state and PcOut (PcIn also from the branch inputs and ImemAck). Instr, InstrPc and the state are registered.
- Reset asserted mid-operation: outputs go to reset values immediately. Reset must cover at least one rising clock edge so the PC register loads RESET_PC. The first request is issued in the first cycle after release.

## Configuration
- FETCH_PERF_EN defined: FetchCount and StallCount ports and counters exist.
  - FetchCount increments when ISSUE & !Stall & !BranchTaken.
  - StallCount increments on cycles that are (ISSUE & Stall) or (FETCH & !ImemAck), excluding BranchTaken cycles.
  - Both wrap modulo 2^32 and reset to 0.
- FETCH_PERF_EN undefined: both ports and all counter logic are absent.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum (FETCH, ISSUE, REDIRECT).
  - INSTR_BYTES = 4.
  - Default RESET_PC constant.
- Sub-module fetch_perf_counter holds the two saturating-free 32-bit counters. It is instantiated only under FETCH_PERF_EN.

## Test plan
- Reset with RESET_PC = 32'h100, memory acks on the first request cycle:
  - PcIn = 32'h100 during reset.
  - ImemAddr = 32'h100, then Instr/InstrPc = ImemData/32'h100 with InstrValid one cycle later.
  - Next request at 32'h104.
- Memory delays ack 3 cycles at PC 32'h200: ImemReq is held with ImemAddr = 32'h200 for 4 cycles. PcOut stays 32'h200 until the ack edge.
- Stall high 5 cycles in ISSUE: InstrValid, Instr and InstrPc are stable for 5 cycles. No request is issued. StallCount += 5 with the macro defined.
- BranchTaken with target 32'h403 in the same cycle as ImemAck:
  - Data is discarded and no InstrValid follows.
  - REDIRECT cycle with ImemReq = 0.
  - Then ImemAddr = 32'h400.
- BranchTaken in ISSUE while Stall = 1: InstrValid drops next cycle. FetchCount does not increment. Fetch resumes at the target.
- PC 32'hFFFF_FFFC is acknowledged: PcIn = 32'h0. The next request goes to address 0.
